// File: rtl/seven_seg_capture.sv
// Receive side of a multiplexed 7-segment bus: synchronizes, debounces and decodes each digit.
// Optional `SEG_HEX_EN adds the A..F glyphs (values 10..15) to the legal decode set.
module seven_seg_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     an_in,
    input  logic                      err_clr,
    output logic [4*NUM_DIGITS-1:0]   digits_out,
    output logic [NUM_DIGITS-1:0]     blank_out,
    output logic [NUM_DIGITS-1:0]     dp_out,
    output logic                      frame_valid,
    output logic                      err_invalid
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    logic [7:0]              seg_s1_q, seg_s2_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    err_q, err_d;

    logic                    sel_legal_c;
    logic                    same_c;
    logic                    capture_c;
    logic [3:0]              dec_val_c;
    logic                    dec_blank_c;
    logic                    dec_legal_c;

    // Two-flop synchronizer followed by the compare register; idle level is all-off/none-selected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q   <= '1;
            seg_s2_q   <= '1;
            seg_prev_q <= '1;
            an_s1_q    <= '1;
            an_s2_q    <= '1;
            an_prev_q  <= '1;
        end else begin
            seg_s1_q   <= seg_in;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            an_s1_q    <= an_in;
            an_s2_q    <= an_s1_q;
            an_prev_q  <= an_s2_q;
        end
    end

    assign sel_legal_c = $onehot(~an_s2_q);
    assign same_c      = (seg_s2_q == seg_prev_q) && (an_s2_q == an_prev_q);

    always_comb begin
        dec_val_c   = 4'd0;
        dec_blank_c = 1'b0;
        dec_legal_c = 1'b1;
        case (seg_s2_q[6:0])
            7'h40: dec_val_c = 4'd0;
            7'h79: dec_val_c = 4'd1;
            7'h24: dec_val_c = 4'd2;
            7'h30: dec_val_c = 4'd3;
            7'h19: dec_val_c = 4'd4;
            7'h12: dec_val_c = 4'd5;
            7'h02: dec_val_c = 4'd6;
            7'h78: dec_val_c = 4'd7;
            7'h00: dec_val_c = 4'd8;
            7'h18: dec_val_c = 4'd9;
            7'h7F: dec_blank_c = 1'b1;
`ifdef SEG_HEX_EN
            7'h08: dec_val_c = 4'd10;
            7'h03: dec_val_c = 4'd11;
            7'h46: dec_val_c = 4'd12;
            7'h21: dec_val_c = 4'd13;
            7'h06: dec_val_c = 4'd14;
            7'h0E: dec_val_c = 4'd15;
`endif
            default: dec_legal_c = 1'b0;
        endcase
    end

    // Dwell FSM: a pattern must repeat STABLE_CYCLES times before a single capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        if (!sel_legal_c) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
                SETTLE: begin
                    if (!same_c) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        capture_c = 1'b1;
                        state_d   = HOLD;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!same_c) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        digits_d      = digits_q;
        blank_d       = blank_q;
        dp_d          = dp_q;
        frame_valid_d = &seen_q;
        seen_d        = (&seen_q) ? '0 : seen_q;
        err_d         = err_q & ~err_clr;
        if (capture_c) begin
            if (dec_legal_c) begin
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    if (!an_s2_q[i]) begin
                        if (!dec_blank_c) begin
                            digits_d[4*i +: 4] = dec_val_c;
                        end
                        blank_d[i] = dec_blank_c;
                        dp_d[i]    = ~seg_s2_q[7];
                        seen_d[i]  = 1'b1;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            digits_q      <= '0;
            blank_q       <= '1;
            dp_q          <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digits_q      <= digits_d;
            blank_q       <= blank_d;
            dp_q          <= dp_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
        end
    end

    assign digits_out  = digits_q;
    assign blank_out   = blank_q;
    assign dp_out      = dp_q;
    assign frame_valid = frame_valid_q;
    assign err_invalid = err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios plus random scans against a run-length reference model.
module tb_seven_seg_capture;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 4;
    localparam int HD = SC + 4;
    localparam logic [11:0] IDLE_SAMPLE = 12'hFFF;

    localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEG_HEX_EN
    localparam int NLEGAL = 16;
`else
    localparam int NLEGAL = 10;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        seg_in;
    logic [ND-1:0]     an_in;
    logic              err_clr;
    logic [4*ND-1:0]   digits_out;
    logic [ND-1:0]     blank_out;
    logic [ND-1:0]     dp_out;
    logic              frame_valid;
    logic              err_invalid;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_cnt = 0;

    logic [15:0] exp_digits;
    logic [3:0]  exp_blank, exp_dp, exp_seen;
    logic        exp_frame, exp_err;
    logic [11:0] hist [HD];

    always #5 clk = ~clk;

    seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .err_clr     (err_clr),
        .digits_out  (digits_out),
        .blank_out   (blank_out),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .err_invalid (err_invalid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void decode(input logic [6:0] p, output logic legal,
                                   output logic blank, output logic [3:0] val);
        legal = 1'b0;
        blank = 1'b0;
        val   = 4'd0;
        if (p == 7'h7F) begin
            legal = 1'b1;
            blank = 1'b1;
        end else begin
            for (int k = 0; k < NLEGAL; k++) begin
                if (PAT[k] == p) begin
                    legal = 1'b1;
                    val   = 4'(k);
                end
            end
        end
    endfunction

    task automatic model_reset();
        exp_digits = '0;
        exp_blank  = '1;
        exp_dp     = '0;
        exp_seen   = '0;
        exp_frame  = 1'b0;
        exp_err    = 1'b0;
        for (int k = 0; k < HD; k++) hist[k] = IDLE_SAMPLE;
    endtask

    // One clock: a pattern is captured once, when its run of samples reaches SC+1 after sync delay
    task automatic step();
        logic        cap, legal, blank, fv;
        logic [3:0]  val, sel, seen_n;
        logic        err_n;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = HD - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {seg_in, an_in};
            cap = 1'b1;
            for (int k = 3; k <= int'(SC) + 2; k++) if (hist[k] != hist[2]) cap = 1'b0;
            if (hist[SC+3] == hist[2]) cap = 1'b0;
            sel = ~hist[2][3:0];
            if (!$onehot(sel)) cap = 1'b0;
            fv     = (exp_seen == 4'hF);
            seen_n = fv ? 4'h0 : exp_seen;
            err_n  = exp_err & ~err_clr;
            if (cap) begin
                decode(hist[2][10:4], legal, blank, val);
                if (legal) begin
                    for (int i = 0; i < 4; i++) begin
                        if (sel[i]) begin
                            if (!blank) exp_digits[4*i +: 4] = val;
                            exp_blank[i] = blank;
                            exp_dp[i]    = ~hist[2][11];
                            seen_n[i]    = 1'b1;
                        end
                    end
                end else begin
                    err_n = 1'b1;
                end
            end
            exp_frame = fv;
            exp_seen  = seen_n;
            exp_err   = err_n;
        end
        #1;
        if (frame_valid) frame_cnt++;
        check_eq("digits", 32'(digits_out), 32'(exp_digits));
        check_eq("blank", 32'(blank_out), 32'(exp_blank));
        check_eq("dp", 32'(dp_out), 32'(exp_dp));
        check_eq("frame_valid", 32'(frame_valid), 32'(exp_frame));
        check_eq("err_invalid", 32'(err_invalid), 32'(exp_err));
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic [15:0] snap;
        int          fc0;
        int          dwell;
        int          pick;
        rst_n   = 1'b0;
        seg_in  = 8'hFF;
        an_in   = 4'hF;
        err_clr = 1'b0;
        model_reset();
        step();
        step();
        check_eq("rst_digits", 32'(digits_out), 32'h0);
        check_eq("rst_blank", 32'(blank_out), 32'hF);
        check_eq("rst_dp", 32'(dp_out), 32'h0);

        // Digit 0 shows "3": captured on the 7th edge after release
        rst_n  = 1'b1;
        an_in  = 4'b1110;
        seg_in = 8'hB0;
        for (int k = 0; k < 6; k++) step();
        check_eq("t1_early", 32'(digits_out[3:0]), 32'h0);
        step();
        check_eq("t1_value", 32'(digits_out[3:0]), 32'h3);
        check_eq("t1_blank", 32'(blank_out[0]), 32'h0);
        check_eq("t1_dp", 32'(dp_out[0]), 32'h0);
        check_eq("t1_frame", 32'(frame_valid), 32'h0);

        fc0 = frame_cnt;
        hold(4'b1110, 8'hF9, 8);
        hold(4'b1101, 8'hA4, 8);
        hold(4'b1011, 8'hB0, 8);
        hold(4'b0111, 8'h99, 8);
        check_eq("t2_digits", 32'(digits_out), 32'h4321);
        check_eq("t2_frames", 32'(frame_cnt - fc0), 32'd1);

        snap = exp_digits;
        for (int k = 0; k < 10; k++) hold(4'b1101, (k % 2 == 0) ? 8'h99 : 8'hC0, 2);
        hold(4'b1100, 8'hC0, 10);
        check_eq("t3_unchanged", 32'(digits_out), 32'(snap));

        hold(4'b1011, 8'hFF, 8);
        check_eq("t4_blank_on", 32'(blank_out[2]), 32'h1);
        hold(4'b1011, 8'h24, 8);
        check_eq("t4_value", 32'(digits_out[11:8]), 32'h2);
        check_eq("t4_blank_off", 32'(blank_out[2]), 32'h0);
        check_eq("t4_dp", 32'(dp_out[2]), 32'h1);

        hold(4'b1110, 8'h88, 8);
`ifdef SEG_HEX_EN
        check_eq("t5_hex_val", 32'(digits_out[3:0]), 32'hA);
        check_eq("t5_hex_err", 32'(err_invalid), 32'h0);
`else
        check_eq("t5_err", 32'(err_invalid), 32'h1);
        check_eq("t5_keep", 32'(digits_out[3:0]), 32'h1);
`endif
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        check_eq("t5_cleared", 32'(err_invalid), 32'h0);

        // Reset in the middle of a dwell; the next capture needs a full dwell again
        hold(4'b0111, 8'h92, 4);
        #2 rst_n = 1'b0;
        #1 check_eq("t6_async_blank", 32'(blank_out), 32'hF);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check_eq("t6_early", 32'(digits_out), 32'h0);
        step();
        check_eq("t6_value", 32'(digits_out[15:12]), 32'h5);

        for (int t = 0; t < 400; t++) begin
            dwell = int'($urandom_range(1, 9));
            an_in = ($urandom_range(0, 99) < 85) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            pick  = int'($urandom_range(0, 18));
            if (pick < 16)       seg_in[6:0] = PAT[pick];
            else if (pick == 16) seg_in[6:0] = 7'h7F;
            else                 seg_in[6:0] = 7'($urandom);
            seg_in[7] = 1'($urandom);
            for (int k = 0; k < dwell; k++) begin
                err_clr = ($urandom_range(0, 19) == 0);
                step();
            end
        end
        err_clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
